mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ACCESS_CYCLES, default 1; number of cycles each memory access holds the shared unified instruction/data memory (legal range 1..15).
REQ-002 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset.
REQ-004 Port: if_req / if_addr  input  1 / 32  instruction-fetch request; word address.
REQ-005 Port: if_ack / if_rdata  output  1 / 32  one-cycle completion pulse; registered fetched word.
REQ-006 Port: d_req / d_we / d_addr / d_wdata  input  1 / 1 / 32 / 32  data request; 1 = store, 0 = load; address; store data.
REQ-007 Port: d_ack / d_rdata  output  1 / 32  one-cycle completion pulse; registered load data.
REQ-008 Port: mem_addr / mem_wdata  output  32 / 32  to the memory Address and Write_data inputs.
REQ-009 Port: mem_read / mem_write  output  1 / 1  to MemRead / MemWrite.
REQ-010 Port: mem_rdata  input  32  from Mem_data (combinational read).

Function
REQ-011 FSM states: IDLE, ACCESS, DONE; reset state IDLE.
REQ-012 IDLE: on an edge with any req high, latch the winner's addr, we and wdata (fetch: we=0), load cnt=ACCESS_CYCLES-1, go to ACCESS.
REQ-013 Arbitration: round-robin via last_grant register; both requesting grants the one not granted last; a single requester always wins; last_grant updates at grant.
REQ-014 ACCESS: mem_addr = latched addr; mem_read = 1 for loads/fetches; mem_write = 1 only while cnt==0 and latched we=1, giving exactly one write edge.
REQ-015 ACCESS: cnt decrements each edge; on the edge with cnt==0, capture mem_rdata into the granted port's rdata register (loads/fetches only) and go to DONE.
REQ-016 DONE: granted port's ack = 1 for exactly one cycle; the other ack stays 0; next edge returns to IDLE.
REQ-017 Latency: ack is high in cycle ACCESS_CYCLES+1, counting the cycle in which req was sampled in IDLE as cycle 0; minimum request spacing is ACCESS_CYCLES+2 cycles.
REQ-018 Handshake: the requester keeps req high until it samples ack; req high in IDLE is always a new request; req is not sampled in ACCESS or DONE.
REQ-019 Inputs may change after the grant edge without effect, since the transaction uses its latched copy.
REQ-020 IDLE and DONE: mem_read = mem_write = 0 and mem_addr = mem_wdata = 0.
REQ-021 Stores leave the requester's rdata register unchanged; rdata holds its value until the next completed read on that port.
REQ-022 Addresses are forwarded unchanged, including addr[1:0] and bits above the memory size.

Reset
REQ-023 When reset is low, immediately force: state=IDLE, cnt=0, last_grant=data (fetch wins the first tie), if_ack=d_ack=0, if_rdata=d_rdata=0, all mem_* outputs 0.
REQ-024 Reset asserted mid-ACCESS aborts the transaction with no write; no ack is produced for it afterwards.

Structure
REQ-025 Package mem_arb_pkg holds the state enum, the grant-id type (GNT_IF, GNT_D) and the ACCESS_CYCLES default.
REQ-026 Sub-module rr_pick2: combinational two-way round-robin picker (inputs: two reqs and last_grant; output: grant id and valid); the FSM, counter and registers stay in mem_arbiter.

Verification
REQ-027 Run all scenarios with ACCESS_CYCLES=2.
REQ-028 Reset release, only if_req with if_addr=0x0, mem_rdata=0x20040005 -> if_ack in cycle 3, if_rdata=0x20040005, mem_write never 1.
REQ-029 d_req, d_we=1, d_addr=0x80, d_wdata=0xDEADBEEF -> mem_write high for exactly one cycle (cycle 2) with mem_addr=0x80, mem_wdata=0xDEADBEEF; d_ack in cycle 3; d_rdata unchanged.
REQ-030 if_req and d_req rise together, first after reset -> fetch acked first; data granted on the next IDLE edge; with both held continuously, grants alternate IF, D, IF, D.
REQ-031 d_addr changed from 0x80 to 0x84 in cycle 1 of a load -> mem_addr stays 0x80 throughout ACCESS.
REQ-032 reset driven low in cycle 2 of a store -> mem_write drops immediately; no ack after release; state IDLE.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and defaults for the unified-memory arbiter
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    typedef enum logic {GNT_IF, GNT_D} gnt_t;
    localparam int ACCESS_CYCLES_DEF = 1;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arb_if: fetch port, data port and memory bus of the arbiter
interface mem_arb_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_rdata;
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_ack, if_rdata, d_ack, d_rdata, mem_addr, mem_wdata, mem_read, mem_write
    );
    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_ack, if_rdata, d_ack, d_rdata, mem_addr, mem_wdata, mem_read, mem_write
    );
endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// rr_pick2: two-way round-robin picker; on a tie the port not granted last wins
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic a_req,
    input  logic b_req,
    input  gnt_t last,
    output gnt_t gnt,
    output logic valid
);
    always_comb begin
        gnt   = (a_req && b_req) ? ((last == GNT_D) ? GNT_IF : GNT_D) : (a_req ? GNT_IF : GNT_D);
        valid = a_req || b_req;
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory between fetch and data ports with a fixed-length access
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ACCESS_CYCLES = ACCESS_CYCLES_DEF
) (
    input logic      clk,
    input logic      reset,
    mem_arb_if.slave bus
);
    state_t     state;
    gnt_t       last;
    gnt_t       pick;
    logic       pick_v;
    logic       pick_we;
    logic       we;
    logic [3:0] cnt;

    rr_pick2 u_pick (
        .a_req(bus.if_req),
        .b_req(bus.d_req),
        .last (last),
        .gnt  (pick),
        .valid(pick_v)
    );

    assign pick_we = (pick == GNT_D) && bus.d_we;

    // last doubles as the owner of the transaction in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            cnt           <= '0;
            last          <= GNT_D;
            we            <= 1'b0;
            bus.if_ack    <= 1'b0;
            bus.d_ack     <= 1'b0;
            bus.if_rdata  <= '0;
            bus.d_rdata   <= '0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_read  <= 1'b0;
            bus.mem_write <= 1'b0;
        end else begin
            bus.if_ack <= 1'b0;
            bus.d_ack  <= 1'b0;
            case (state)
                IDLE: if (pick_v) begin
                    state         <= ACCESS;
                    last          <= pick;
                    cnt           <= 4'(ACCESS_CYCLES - 1);
                    we            <= pick_we;
                    bus.mem_addr  <= (pick == GNT_D) ? bus.d_addr : bus.if_addr;
                    bus.mem_wdata <= (pick == GNT_D) ? bus.d_wdata : 32'h0;
                    bus.mem_read  <= !pick_we;
                    bus.mem_write <= pick_we && (ACCESS_CYCLES == 1);
                end
                ACCESS: begin
                    cnt           <= cnt - 4'd1;
                    bus.mem_write <= we && (cnt == 4'd1);
                    if (cnt == 4'd0) begin
                        state         <= DONE;
                        cnt           <= '0;
                        bus.mem_addr  <= '0;
                        bus.mem_wdata <= '0;
                        bus.mem_read  <= 1'b0;
                        bus.mem_write <= 1'b0;
                        if (last == GNT_IF) begin
                            bus.if_ack <= 1'b1;
                            if (!we) bus.if_rdata <= bus.mem_rdata;
                        end else begin
                            bus.d_ack <= 1'b1;
                            if (!we) bus.d_rdata <= bus.mem_rdata;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with ACCESS_CYCLES=2
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam logic [31:0] K = 32'h2004_0005;

    typedef struct {
        bit          p;
        logic [31:0] rd;
    } sb_t;

    logic clk;
    logic reset;
    int tests = 0;
    int fails = 0;
    sb_t sbq[$];
    logic [31:0] exp_if = '0;
    logic [31:0] exp_d = '0;

    mem_arb_if bus ();

    mem_arbiter #(.ACCESS_CYCLES(2)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    assign bus.mem_rdata = bus.mem_addr ^ K;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_reset();
        reset = 1'b0;
        bus.if_req = 1'b0;
        bus.d_req = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        exp_if = '0;
        exp_d = '0;
        sbq.delete();
    endtask

    task automatic run_txn(input bit p, input bit w, input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] a2, output int ack_c, output int wr_n, output int wr_c,
                           output logic [31:0] wr_a, output logic [31:0] wr_d, output int rd_n,
                           output bit oth, output bit abad, output bit ibad);
        sb_t e;
        e.p = p;
        e.rd = w ? (p ? exp_d : exp_if) : (a ^ K);
        sbq.push_back(e);
        if (!w) begin
            if (p) exp_d = a ^ K;
            else exp_if = a ^ K;
        end
        if (p) begin
            bus.d_req = 1'b1;
            bus.d_we = w;
            bus.d_addr = a;
            bus.d_wdata = wd;
        end else begin
            bus.if_req = 1'b1;
            bus.if_addr = a;
        end
        ack_c = -1; wr_n = 0; wr_c = -1; wr_a = '0; wr_d = '0; rd_n = 0; oth = 0; abad = 0; ibad = 0;
        for (int k = 0; k < 12 && ack_c < 0; k++) begin
            @(negedge clk);
            if (bus.mem_write) begin
                wr_n++;
                wr_c = k;
                wr_a = bus.mem_addr;
                wr_d = bus.mem_wdata;
            end
            if (bus.mem_read) rd_n++;
            if ((k == 1 || k == 2) && bus.mem_addr !== a) abad = 1;
            if (p ? bus.if_ack : bus.d_ack) oth = 1;
            if (p ? bus.d_ack : bus.if_ack) begin
                ack_c = k;
                if ({bus.mem_read, bus.mem_write, bus.mem_addr, bus.mem_wdata} !== '0) ibad = 1;
                bus.if_req = 1'b0;
                bus.d_req = 1'b0;
            end
            if (k == 0 && {bus.mem_read, bus.mem_write, bus.mem_addr, bus.mem_wdata} !== '0) ibad = 1;
            if (k == 1 && p) bus.d_addr = a2;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++;
        if ({bus.if_ack, bus.d_ack, bus.if_rdata, bus.d_rdata, bus.mem_addr, bus.mem_wdata,
             bus.mem_read, bus.mem_write} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got acks=%b%b memrw=%b%b addr=%h wdata=%h expected all zero",
                     bus.if_ack, bus.d_ack, bus.mem_read, bus.mem_write, bus.mem_addr, bus.mem_wdata);
        end
        tests++;
        if (dut.state !== IDLE || dut.last !== GNT_D || dut.cnt !== 4'd0) begin
            fails++;
            $display("FAIL reset_state: got state=%0d last=%0d cnt=%0d expected 0 1 0",
                     dut.state, dut.last, dut.cnt);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_fetch();
        int ack_c, wr_n, wr_c, rd_n;
        logic [31:0] wr_a, wr_d;
        bit oth, abad, ibad;
        sb_t e;
        run_txn(0, 0, 32'h0, 32'h0, 32'h0, ack_c, wr_n, wr_c, wr_a, wr_d, rd_n, oth, abad, ibad);
        e = sbq.pop_front();
        tests++;
        if (ack_c !== 3) begin fails++; $display("FAIL fetch_latency: got %0d expected 3", ack_c); end
        tests++;
        if (bus.if_rdata !== 32'h2004_0005) begin
            fails++; $display("FAIL fetch_rdata: got %h expected 20040005", bus.if_rdata);
        end
        tests++;
        if (bus.if_rdata !== e.rd) begin fails++; $display("FAIL fetch_sb: got %h expected %h", bus.if_rdata, e.rd); end
        tests++;
        if (wr_n !== 0) begin fails++; $display("FAIL fetch_nowrite: got %0d writes expected 0", wr_n); end
        tests++;
        if (rd_n !== 2 || oth !== 0 || ibad !== 0) begin
            fails++; $display("FAIL fetch_bus: got reads=%0d other_ack=%0d idle_bad=%0d expected 2 0 0", rd_n, oth, ibad);
        end
    endtask

    task automatic test_store();
        int ack_c, wr_n, wr_c, rd_n;
        logic [31:0] wr_a, wr_d;
        bit oth, abad, ibad;
        sb_t e;
        run_txn(1, 1, 32'h80, 32'hDEAD_BEEF, 32'h80, ack_c, wr_n, wr_c, wr_a, wr_d, rd_n, oth, abad, ibad);
        e = sbq.pop_front();
        tests++;
        if (wr_n !== 1 || wr_c !== 2) begin
            fails++; $display("FAIL store_write_pulse: got %0d writes last in cycle %0d expected 1 in cycle 2", wr_n, wr_c);
        end
        tests++;
        if (wr_a !== 32'h80 || wr_d !== 32'hDEAD_BEEF) begin
            fails++; $display("FAIL store_write_bus: got addr=%h data=%h expected 00000080 deadbeef", wr_a, wr_d);
        end
        tests++;
        if (ack_c !== 3) begin fails++; $display("FAIL store_latency: got %0d expected 3", ack_c); end
        tests++;
        if (bus.d_rdata !== e.rd) begin fails++; $display("FAIL store_rdata_kept: got %h expected %h", bus.d_rdata, e.rd); end
        tests++;
        if (rd_n !== 0 || oth !== 0 || ibad !== 0) begin
            fails++; $display("FAIL store_bus: got reads=%0d other_ack=%0d idle_bad=%0d expected 0 0 0", rd_n, oth, ibad);
        end
    endtask

    task automatic test_load_addr_change();
        int ack_c, wr_n, wr_c, rd_n;
        logic [31:0] wr_a, wr_d;
        bit oth, abad, ibad;
        sb_t e;
        run_txn(1, 0, 32'h80, 32'h0, 32'h84, ack_c, wr_n, wr_c, wr_a, wr_d, rd_n, oth, abad, ibad);
        e = sbq.pop_front();
        tests++;
        if (abad !== 0) begin fails++; $display("FAIL load_addr_latched: got changed addr flag %0d expected 0", abad); end
        tests++;
        if (ack_c !== 3) begin fails++; $display("FAIL load_latency: got %0d expected 3", ack_c); end
        tests++;
        if (bus.d_rdata !== e.rd) begin fails++; $display("FAIL load_rdata: got %h expected %h", bus.d_rdata, e.rd); end
        tests++;
        if (wr_n !== 0 || rd_n !== 2 || oth !== 0) begin
            fails++; $display("FAIL load_bus: got writes=%0d reads=%0d other_ack=%0d expected 0 2 0", wr_n, rd_n, oth);
        end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        bit both = 0;
        bit p;
        sb_t e;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            e.p = (i % 2) == 1;
            e.rd = e.p ? (32'h200 ^ K) : (32'h100 ^ K);
            sbq.push_back(e);
        end
        exp_if = 32'h100 ^ K;
        exp_d = 32'h200 ^ K;
        bus.if_req = 1'b1;
        bus.if_addr = 32'h100;
        bus.d_req = 1'b1;
        bus.d_we = 1'b0;
        bus.d_addr = 32'h200;
        for (int k = 0; k < 40 && n < 4; k++) begin
            @(negedge clk);
            if (bus.if_ack && bus.d_ack) both = 1;
            if (bus.if_ack || bus.d_ack) begin
                e = sbq.pop_front();
                p = bus.d_ack;
                tests++;
                if (p !== e.p) begin fails++; $display("FAIL rr_order%0d: got port %0d expected %0d", n, p, e.p); end
                tests++;
                if ((p ? bus.d_rdata : bus.if_rdata) !== e.rd) begin
                    fails++; $display("FAIL rr_rdata%0d: got %h expected %h", n, p ? bus.d_rdata : bus.if_rdata, e.rd);
                end
                tests++;
                if (k !== 3 + 4 * n) begin fails++; $display("FAIL rr_cycle%0d: got %0d expected %0d", n, k, 3 + 4 * n); end
                n++;
                if (n == 4) begin
                    bus.if_req = 1'b0;
                    bus.d_req = 1'b0;
                end
            end
        end
        @(posedge clk);
        #1;
        tests++;
        if (n !== 4 || both !== 0) begin
            fails++; $display("FAIL rr_count: got %0d acks both=%0d expected 4 0", n, both);
        end
    endtask

    task automatic test_reset_mid_store();
        int acks = 0;
        bus.d_req = 1'b1;
        bus.d_we = 1'b1;
        bus.d_addr = 32'h90;
        bus.d_wdata = 32'hCAFE_F00D;
        repeat (3) @(negedge clk);
        tests++;
        if (bus.mem_write !== 1'b1) begin fails++; $display("FAIL abort_pre_write: got %b expected 1", bus.mem_write); end
        #1;
        reset = 1'b0;
        bus.d_req = 1'b0;
        #1;
        tests++;
        if (bus.mem_write !== 1'b0 || bus.mem_addr !== 32'h0 || dut.state !== IDLE) begin
            fails++; $display("FAIL abort_immediate: got write=%b addr=%h state=%0d expected 0 0 0",
                              bus.mem_write, bus.mem_addr, dut.state);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        exp_if = '0;
        exp_d = '0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.if_ack || bus.d_ack || bus.mem_write) acks++;
        end
        tests++;
        if (acks !== 0) begin fails++; $display("FAIL abort_no_ack: got %0d ack/write cycles expected 0", acks); end
        tests++;
        if (dut.state !== IDLE || bus.d_rdata !== exp_d || bus.if_rdata !== exp_if) begin
            fails++; $display("FAIL abort_final: got state=%0d d_rdata=%h if_rdata=%h expected 0 %h %h",
                              dut.state, bus.d_rdata, bus.if_rdata, exp_d, exp_if);
        end
    endtask

    initial begin
        reset = 1'b0;
        bus.if_req = 1'b0;
        bus.if_addr = '0;
        bus.d_req = 1'b0;
        bus.d_we = 1'b0;
        bus.d_addr = '0;
        bus.d_wdata = '0;
        test_reset();
        test_fetch();
        test_store();
        test_load_addr_change();
        test_back_to_back();
        test_reset_mid_store();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
